signed_frame_accumulator: RTL and testbench
===========================================

# signed_frame_accumulator

Streaming consumer for the 4-bit signed adder stage. It accepts a stream of two's-complement sums together with their per-sample overflow flags and accumulates N samples per frame into a wider saturating accumulator. At the end of each frame it presents the frame total, a sticky saturation flag and a count of overflowed inputs through a valid/ready output handshake. It sits directly downstream of the signed add-with-overflow stage.

## Interface
- `W`, 4: input sample width (signed).
- `ACC_W`, 6: accumulator/output width (signed); must be > `W`.
- `N`, 8: samples per frame; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  W  signed sample (upstream `sum`).
- `in_overflow`  in  1  upstream overflow flag for this sample.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  ACC_W  saturated signed frame total.
- `out_sat`  out  1  saturation occurred at least once in the frame.
- `out_ovf_cnt`  out  $clog2(N+1)  number of frame samples with `in_overflow`=1.

## Operation
- States: ACC (collecting samples) and OUT (holding the result).
- ACC: `in_ready`=1, `out_valid`=0. An input handshake occurs when `in_valid` && `in_ready`.
- On each handshake, `acc` ← sat(`acc` + sign-extend(`in_data`)).
  - The sum is computed at ACC_W+1 bits.
  - Overflow is detected when the two operand signs are equal and the result sign differs.
  - Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
  - Any clamp sets sticky `sat`.
- Overflowed inputs are accumulated as their wrapped W-bit value, unmodified; `ovf_cnt` increments when `in_overflow`=1.
- A sample counter `cnt` counts handshakes 0..N-1. A handshake with `cnt`==N-1 updates `acc`/`sat`/`ovf_cnt` with that sample and moves the FSM to OUT.
- OUT: `in_ready`=0, `out_valid`=1.
  - `out_sum`, `out_sat` and `out_ovf_cnt` are driven from registers and stay stable until the output handshake.
  - On `out_valid` && `out_ready`: clear `acc`, `sat`, `ovf_cnt` and `cnt`, then return to ACC.
- No input is accepted in the cycle of the output handshake; input acceptance resumes on the following cycle.
- `in_valid` low in ACC: state is held and no sample is counted.
- `out_ready` high while in ACC has no effect.
- Reset values: state=ACC, `acc`=0, `sat`=0, `ovf_cnt`=0, `cnt`=0, so `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_sat`=0, `out_ovf_cnt`=0.
- Reset mid-frame or while in OUT discards the partial frame or pending result. No output is produced for that frame.

## Timing
- `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the cycle after the Nth input handshake.
- Peak throughput: one frame per N+1 cycles. This requires continuous `in_valid` and `out_ready` held at 1 (N accept cycles plus 1 output cycle).
- Backpressure: with `out_ready`=0 the block remains in OUT indefinitely, and `in_ready` stays 0.
- `rst` is sampled on the clock edge; outputs show their reset values in the cycle after `rst` is sampled high.

## Structure
- Shared package `signed_acc_pkg`:
  - `state_t` enum {ACC, OUT}.
  - Function `sat_add` (parameterized by width via a constant or let), returning the sum and a clamp flag.
- One sub-module: `signed_sat_add`. It is combinational: ACC_W-bit a, ACC_W-bit b → ACC_W-bit sum plus `sat` flag, and it reuses the sign-compare overflow rule.
- Top level contains the FSM, `cnt`, and the `acc`/`sat`/`ovf_cnt` registers.

## Test plan
All scenarios use the defaults W=4, ACC_W=6, N=8.
- Reset, then idle: `in_ready`=1, `out_valid`=0, all outputs 0.
- Samples 3,-2,7,-8,1,1,0,-1 with continuous valid and `out_ready`=1:
  - `out_valid` rises exactly one cycle after the 8th handshake.
  - Expect `out_sum`=1, `out_sat`=0, `out_ovf_cnt`=0.
  - Next frame acceptance starts 2 cycles after the 8th handshake.
- Positive saturation: eight samples of +7 → `out_sum`=31, `out_sat`=1.
- Negative bound and saturation:
  - Eight samples of -4 → `out_sum`=-32, `out_sat`=0.
  - Eight samples of -8 → `out_sum`=-32, `out_sat`=1.
- Overflow flags, valid gaps and backpressure:
  - `in_overflow`=1 on samples 2 and 5; random `in_valid` gaps; `out_ready` held 0 for 5 cycles.
  - Expect `out_ovf_cnt`=2, outputs stable while stalled, and `in_ready`=0 throughout the stall.
- Reset mid-frame: 4 samples of +5, then `rst` for 1 cycle, then 8 samples of +1 → `out_sum`=8, `out_ovf_cnt`=0; no result is produced for the aborted frame.

Source files
------------

// File: rtl/signed_acc_pkg.sv
// Shared types and saturating-add helper for the signed frame accumulator.
// The overflow rule lives here once so every adder applies the same sign test.
package signed_acc_pkg;

   typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

   // Width used by sat_add; matches the default accumulator width.
   localparam int SAT_W = 6;

   typedef struct packed {
      logic [SAT_W-1:0] sum;
      logic             sat;
   } sat_res_t;

   // Overflow: both operands share a sign and the truncated result does not.
   function automatic logic ovf_rule(input logic sa, input logic sb, input logic ss);
      return (sa == sb) && (ss != sa);
   endfunction

   function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b);
      logic [SAT_W:0] s;
      sat_res_t       r;
      s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
      r.sat = ovf_rule(a[SAT_W-1], b[SAT_W-1], s[SAT_W-1]);
      if (r.sat)
         r.sum = s[SAT_W] ? {1'b1, {(SAT_W-1){1'b0}}} : {1'b0, {(SAT_W-1){1'b1}}};
      else
         r.sum = s[SAT_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/signed_sat_add.sv
// Combinational signed saturating adder: a + b clamped to the ACC_W-bit range,
// with sat flagging that a clamp happened.
module signed_sat_add
   import signed_acc_pkg::*;
#(
   parameter int ACC_W = 6
)(
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             sat
);

   generate
      if (ACC_W == SAT_W) begin : g_pkg
         sat_res_t r;
         always_comb r = sat_add(a, b);
         assign sum = r.sum;
         assign sat = r.sat;
      end else begin : g_gen
         // Same rule as sat_add, for widths other than the package default.
         logic [ACC_W:0] s;
         always_comb begin
            s   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
            sat = ovf_rule(a[ACC_W-1], b[ACC_W-1], s[ACC_W-1]);
            if (sat)
               sum = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
               sum = s[ACC_W-1:0];
         end
      end
   endgenerate

endmodule

// File: rtl/signed_frame_accumulator.sv
// Accumulates N signed samples per frame into a saturating ACC_W-bit total and
// presents total, sticky saturation and overflow count through valid/ready.
module signed_frame_accumulator
   import signed_acc_pkg::*;
#(
   parameter int W     = 4,
   parameter int ACC_W = 6,
   parameter int N     = 8
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_data,
   input  logic                     in_overflow,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         out_sum,
   output logic                     out_sat,
   output logic [$clog2(N+1)-1:0]   out_ovf_cnt
);

   localparam int CNT_W = $clog2(N);
   localparam int OC_W  = $clog2(N+1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic              sat;
   logic [OC_W-1:0]   ovf_cnt;

   logic [ACC_W-1:0]  in_ext;
   logic [ACC_W-1:0]  add_sum;
   logic              add_sat;
   logic              take;
   logic              last;
   logic              give;

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // Both ready/valid outputs come from the state register alone, so neither
   // depends combinationally on in_valid or out_ready.
   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);

   assign in_ext = {{(ACC_W-W){in_data[W-1]}}, in_data};
   assign take   = in_valid && in_ready;
   assign give   = out_valid && out_ready;
   assign last   = (cnt == CNT_W'(N-1));

   signed_sat_add #(.ACC_W(ACC_W)) u_add (
      .a   (acc),
      .b   (in_ext),
      .sum (add_sum),
      .sat (add_sat)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ACC: if (take && last) state_nxt = OUT;
         OUT: if (out_ready)    state_nxt = ACC;
         default:               state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ACC;
         cnt     <= '0;
         acc     <= '0;
         sat     <= 1'b0;
         ovf_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (give) begin
            cnt     <= '0;
            acc     <= '0;
            sat     <= 1'b0;
            ovf_cnt <= '0;
         end else if (take) begin
            acc <= add_sum;
            sat <= sat | add_sat;
            if (in_overflow) ovf_cnt <= ovf_cnt + OC_W'(1);
            cnt <= last ? '0 : cnt + CNT_W'(1);
         end
      end
   end

   assign out_sum     = acc;
   assign out_sat     = sat;
   assign out_ovf_cnt = ovf_cnt;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Directed + randomized bench for signed_frame_accumulator against an
// arithmetic frame model with an expected-result queue.
module tb_signed_frame_accumulator;

   localparam int W     = 4;
   localparam int ACC_W = 6;
   localparam int N     = 8;
   localparam int OC_W  = $clog2(N+1);
   localparam int EXP_W = ACC_W + 1 + OC_W;
   localparam int ACC_MAX = (1 << (ACC_W-1)) - 1;
   localparam int ACC_MIN = -(1 << (ACC_W-1));

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      in_data = '0;
   logic              in_overflow = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ACC_W-1:0]  out_sum;
   logic              out_sat;
   logic [OC_W-1:0]   out_ovf_cnt;

   signed_frame_accumulator #(.W(W), .ACC_W(ACC_W), .N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_overflow (in_overflow),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_sat     (out_sat),
      .out_ovf_cnt (out_ovf_cnt)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;
   int results_seen = 0;
   int first_hs = 0;
   int last_hs  = 0;
   logic pre_ov = 1'b0;

   int smp[N];
   bit ovfs[N];
   logic [EXP_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // reference model: running signed sum clamped after every sample
   task automatic push_expected();
      int acc = 0;
      bit sat = 0;
      int oc  = 0;
      logic [ACC_W-1:0] s;
      logic [OC_W-1:0]  o;
      for (int i = 0; i < N; i++) begin
         acc = acc + smp[i];
         if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
         if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
         if (ovfs[i]) oc++;
      end
      s = ACC_W'(acc);
      o = OC_W'(oc);
      exp_q.push_back({s, sat, o});
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) begin smp[i] = v; ovfs[i] = 1'b0; end
   endtask

   task automatic fill_random(input bit rand_ovf);
      for (int i = 0; i < N; i++) begin
         smp[i]  = int'($urandom_range(0, 15)) - 8;
         ovfs[i] = rand_ovf ? bit'($urandom_range(0, 1)) : 1'b0;
      end
   endtask

   // driver: called #1 after a rising edge; returns #1 after the edge of the last handshake
   task automatic drive_frame(input int n, input int gap_pct, input bit keep_valid);
      int idx = 0;
      int budget = 400;
      bit hs;
      while (idx < n && budget > 0) begin
         if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            in_valid = 1'b0;
         end else begin
            in_valid    = 1'b1;
            in_data     = W'(smp[idx]);
            in_overflow = ovfs[idx];
         end
         hs     = in_valid && in_ready;
         pre_ov = out_valid;
         @(posedge clk); #1;
         budget--;
         if (hs) begin
            if (idx == 0) first_hs = cyc;
            idx++;
            if (idx == n) last_hs = cyc;
         end
      end
      if (!keep_valid) in_valid = 1'b0;
      check("drive_done", idx, n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // scoreboard: compare each delivered frame with the head of the queue
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         results_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("out_sum", out_sum, e[EXP_W-1 -: ACC_W]);
            check("out_sat", out_sat, e[OC_W]);
            check("out_ovf_cnt", out_ovf_cnt, e[OC_W-1:0]);
         end
      end
   end

   initial begin
      logic [EXP_W-1:0] head;
      int a_last;
      int k;

      // reset and idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_out_ovf", out_ovf_cnt, 0);

      // frame A: mixed samples, continuous valid, latency and throughput
      out_ready = 1'b1;
      smp = '{3, -2, 7, -8, 1, 1, 0, -1};
      ovfs = '{default: 1'b0};
      push_expected();
      drive_frame(N, 0, 1'b1);
      check("lat_pre_low", pre_ov, 0);
      check("lat_rise", out_valid, 1);
      check("in_ready_in_out", in_ready, 0);
      a_last = last_hs;

      // frame B: positive saturation, driven back-to-back
      fill_const(7);
      push_expected();
      drive_frame(N, 0, 1'b0);
      check("next_accept_gap", first_hs - a_last, 2);

      // frames C/D: negative bound exactly, then negative saturation
      fill_const(-4);
      push_expected();
      drive_frame(N, 0, 1'b0);
      fill_const(-8);
      push_expected();
      drive_frame(N, 0, 1'b0);

      // frame E: overflow flags on samples 2 and 5, valid gaps, backpressure
      @(posedge clk); #1;
      out_ready = 1'b0;
      fill_random(1'b0);
      ovfs[1] = 1'b1;
      ovfs[4] = 1'b1;
      push_expected();
      drive_frame(N, 40, 1'b1);
      k = 0;
      while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
      check("stall_out_valid_seen", out_valid, 1);
      head = exp_q[exp_q.size()-1];
      check("ovf_cnt_two", out_ovf_cnt, 2);
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
         check("stall_sum", out_sum, head[EXP_W-1 -: ACC_W]);
         check("stall_sat", out_sat, head[OC_W]);
         check("stall_ovf", out_ovf_cnt, head[OC_W-1:0]);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      check("after_stall_valid", out_valid, 0);
      check("after_stall_ready", in_ready, 1);

      // frame F: fully random data and overflow flags with gaps
      fill_random(1'b1);
      push_expected();
      drive_frame(N, 30, 1'b0);
      @(posedge clk); #1;

      // reset mid-frame: aborted partial frame must never be delivered
      fill_const(5);
      drive_frame(4, 0, 1'b0);
      do_reset();
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", out_sum, 0);
      fill_const(1);
      push_expected();
      drive_frame(N, 0, 1'b0);

      k = 0;
      while (exp_q.size() > 0 && k < 50) begin @(posedge clk); #1; k++; end
      check("queue_drained", exp_q.size(), 0);
      check("results_seen", results_seen, 7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
